fp_sqrt_seq: RTL and testbench

FP_SQRT_SEQ -- requirements
Module: fp_sqrt_seq

---
 rtl/fp_sqrt_pkg.sv | 35 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_sqrt_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_sqrt_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the sequential floating-point square root.
// Holds the controller state enum, the operand class enum and the canonical NaN builder.
package fp_sqrt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ITER,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_PINF,
    CLS_PZERO,
    CLS_NZERO,
    CLS_NEG,
    CLS_SUB,
    CLS_NORMAL
  } op_class_t;

  localparam int MAX_NAN_W = 128;

  // Canonical NaN: sign set, exponent all ones, only the fraction MSB set.
  function automatic logic [MAX_NAN_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [MAX_NAN_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    v[man_w+exp_w] = 1'b1;
    v[man_w-1]     = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754-style square root: classify/normalise, one root bit per
// cycle by restoring recurrence, then round-to-nearest-even.
module fp_sqrt_seq
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [EXP_W+MAN_W:0] IN_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [EXP_W+MAN_W:0] OUT_DATA,
  output logic               IS_NAN,
  output logic               IS_PINF,
  output logic               IS_INVALID,
  output logic               IS_INEXACT
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int SIG_W  = MAN_W + 1;
  localparam int ROOT_W = MAN_W + 2;
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = MAN_W + 4;
  localparam int TRY_W  = REM_W + 3;
  localparam int LZ_W   = $clog2(MAN_W + 1);
  localparam int EW     = EXP_W + LZ_W + 2;
  localparam int CNT_W  = $clog2(MAN_W + 3);
  localparam logic [MAX_NAN_W-1:0] CNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] CNAN = CNAN_FULL[W-1:0];

  state_t                state_q, state_d;
  op_class_t             op_class;
  logic [W-1:0]          op_q;
  logic [RAD_W-1:0]      rad_q;
  logic [REM_W-1:0]      rem_q;
  logic [ROOT_W-1:0]     root_q;
  logic [CNT_W-1:0]      cnt_q;
  logic signed [EW-1:0]  rexp_q;
  logic [W-1:0]          out_data_q;
  logic                  nan_q, pinf_q, invalid_q, inexact_q;

  logic                  op_sign;
  logic [EXP_W-1:0]      op_exp;
  logic [MAN_W-1:0]      op_frac;
  logic [LZ_W-1:0]       lz;

  assign op_sign = op_q[W-1];
  assign op_exp  = op_q[W-2:MAN_W];
  assign op_frac = op_q[MAN_W-1:0];

  fp_lzc #(.WIDTH(MAN_W), .CNT_W(LZ_W)) u_lzc (
    .data  (op_frac),
    .count (lz)
  );

  // NaN takes precedence over the sign so negative NaNs still propagate.
  always_comb begin
    op_class = CLS_NORMAL;
    if (&op_exp) op_class = (|op_frac) ? CLS_NAN : (op_sign ? CLS_NEG : CLS_PINF);
    else if (~|op_exp && ~|op_frac) op_class = op_sign ? CLS_NZERO : CLS_PZERO;
    else if (op_sign) op_class = CLS_NEG;
    else if (~|op_exp) op_class = CLS_SUB;
  end

  logic [LZ_W:0]         shift;
  logic [SIG_W-1:0]      sig_norm;
  logic [ROOT_W-1:0]     sig_adj;
  logic signed [EW-1:0]  e_unb, e_even, half_e, res_exp;

  // An odd exponent is absorbed into the significand so the halving is exact.
  always_comb begin
    shift = {1'b0, lz} + (LZ_W + 1)'(1);
    if (op_class == CLS_SUB) begin
      sig_norm = {1'b0, op_frac} << shift;
      e_unb    = EW'(1 - BIAS) - EW'(shift);
    end else begin
      sig_norm = {1'b1, op_frac};
      e_unb    = EW'(op_exp) - EW'(BIAS);
    end
    if (e_unb[0]) begin
      sig_adj = {sig_norm, 1'b0};
      e_even  = e_unb - EW'(1);
    end else begin
      sig_adj = {1'b0, sig_norm};
      e_even  = e_unb;
    end
    half_e  = e_even >>> 1;
    res_exp = half_e + EW'(BIAS);
  end

  logic                  special, spec_nan, spec_pinf, spec_inv;
  logic [W-1:0]          spec_data;

  always_comb begin
    special   = 1'b1;
    spec_data = op_q;
    spec_nan  = 1'b0;
    spec_pinf = 1'b0;
    spec_inv  = 1'b0;
    case (op_class)
      CLS_NAN: begin
        spec_data[MAN_W-1] = 1'b1;
        spec_nan           = 1'b1;
        spec_inv           = ~op_frac[MAN_W-1];
      end
      CLS_PINF: spec_pinf = 1'b1;
      CLS_NEG: begin
        spec_data = CNAN;
        spec_nan  = 1'b1;
        spec_inv  = 1'b1;
      end
      CLS_PZERO, CLS_NZERO: special = 1'b1;
      default: special = 1'b0;
    endcase
  end

  logic [TRY_W-1:0]      rem_shift, trial;
  logic                  trial_ok;

  assign rem_shift = TRY_W'({rem_q, rad_q[RAD_W-1 -: 2]});
  assign trial     = rem_shift - TRY_W'({root_q, 2'b01});
  assign trial_ok  = ~trial[TRY_W-1];

  logic                  guard, sticky, round_up;
  logic [ROOT_W-1:0]     rsum;
  logic signed [EW-1:0]  fin_exp;
  logic [W-1:0]          round_data;

  // A carry out of the significand leaves the fraction bits zero and bumps the exponent.
  assign guard      = root_q[0];
  assign sticky     = |rem_q;
  assign round_up   = guard & (sticky | root_q[1]);
  assign rsum       = {1'b0, root_q[ROOT_W-1:1]} + ROOT_W'(round_up);
  assign fin_exp    = rsum[ROOT_W-1] ? rexp_q + EW'(1) : rexp_q;
  assign round_data = {1'b0, fin_exp[EXP_W-1:0], rsum[MAN_W-1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = ~RST;
        if (IN_VALID) state_d = NORM;
      end
      NORM:  state_d = special ? DONE : ITER;
      ITER:  if (cnt_q == CNT_W'(MAN_W + 1)) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q       <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      rexp_q     <= '0;
      out_data_q <= '0;
      nan_q      <= 1'b0;
      pinf_q     <= 1'b0;
      invalid_q  <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (IN_VALID) op_q <= IN_DATA;
        NORM: begin
          rad_q  <= {sig_adj, {ROOT_W{1'b0}}};
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
          rexp_q <= res_exp;
          if (special) begin
            out_data_q <= spec_data;
            nan_q      <= spec_nan;
            pinf_q     <= spec_pinf;
            invalid_q  <= spec_inv;
            inexact_q  <= 1'b0;
          end
        end
        ITER: begin
          rad_q  <= rad_q << 2;
          rem_q  <= trial_ok ? trial[REM_W-1:0] : rem_shift[REM_W-1:0];
          root_q <= {root_q[ROOT_W-2:0], trial_ok};
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        ROUND: begin
          out_data_q <= round_data;
          nan_q      <= 1'b0;
          pinf_q     <= 1'b0;
          invalid_q  <= 1'b0;
          inexact_q  <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

  assign OUT_DATA   = out_data_q;
  assign IS_NAN     = nan_q;
  assign IS_PINF    = pinf_q;
  assign IS_INVALID = invalid_q;
  assign IS_INEXACT = inexact_q;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Self-checking bench for fp_sqrt_seq: directed vector table, handshake/reset
// sequences and random operands against an integer-sqrt reference model.
module tb_fp_sqrt_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0;
  logic        nan0, pinf0, inv0, inex0;
  logic [15:0] id0 = '0, od0;

  logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0;
  logic        nan1, pinf1, inv1, inex1;
  logic [31:0] id1 = '0, od1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fp_sqrt_seq dut (
    .CLK(CLK), .RST(RST), .IN_VALID(iv0), .IN_READY(ir0), .IN_DATA(id0),
    .OUT_VALID(ov0), .OUT_READY(ordy0), .OUT_DATA(od0),
    .IS_NAN(nan0), .IS_PINF(pinf0), .IS_INVALID(inv0), .IS_INEXACT(inex0)
  );

  fp_sqrt_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv1), .IN_READY(ir1), .IN_DATA(id1),
    .OUT_VALID(ov1), .OUT_READY(ordy1), .OUT_DATA(od1),
    .IS_NAN(nan1), .IS_PINF(pinf1), .IS_INVALID(inv1), .IS_INEXACT(inex1)
  );

  typedef struct {
    int          which;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic getReady(input int which);
    return (which == 0) ? ir0 : ir1;
  endfunction

  function automatic logic getValid(input int which);
    return (which == 0) ? ov0 : ov1;
  endfunction

  function automatic logic [31:0] getData(input int which);
    return (which == 0) ? {16'h0, od0} : od1;
  endfunction

  function automatic logic [3:0] getFlags(input int which);
    return (which == 0) ? {nan0, pinf0, inv0, inex0} : {nan1, pinf1, inv1, inex1};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic startOp(input int which, input logic [31:0] din);
    int n;
    @(negedge CLK);
    n = 0;
    while (!getReady(which) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (which == 0) begin iv0 = 1'b1; id0 = din[15:0]; end
    else begin iv1 = 1'b1; id1 = din; end
    @(posedge CLK);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic waitResult(input int which, output int lat);
    lat = 1;
    while (!getValid(which) && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic releaseOut(input int which);
    @(negedge CLK);
    if (which == 0) ordy0 = 1'b1; else ordy1 = 1'b1;
    @(posedge CLK);
    #1;
    ordy0 = 1'b0;
    ordy1 = 1'b0;
  endtask

  task automatic applyStimulus(input int which, input logic [31:0] din,
                               output logic [31:0] dout, output logic [3:0] fl, output int lat);
    startOp(which, din);
    waitResult(which, lat);
    dout = getData(which);
    fl   = getFlags(which);
    releaseOut(which);
  endtask

  function automatic int bitlen(input longint unsigned v);
    int n = 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo = 0, hi = 64'd1 << 30, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  // Reference: value = m * 2^e2, scaled so the integer root carries spare bits, then RNE.
  task automatic refSqrt(input logic [31:0] x, input int ew, input int mw,
                         output logic [31:0] res, output logic inexact);
    int bias, e2, s, d, rexp;
    longint unsigned ex, f, m, n, r, kept;
    logic g, st;
    bias = (1 << (ew - 1)) - 1;
    ex   = (longint'(x) >> mw) & ((64'd1 << ew) - 1);
    f    = longint'(x) & ((64'd1 << mw) - 1);
    if (ex == 0) begin m = f; e2 = 1 - bias - mw; end
    else begin m = f + (64'd1 << mw); e2 = int'(ex) - bias - mw; end
    s = 2 * mw + 6 - bitlen(m);
    if (((e2 - s) % 2) != 0) s++;
    n    = m << s;
    r    = isqrt(n);
    d    = bitlen(r) - (mw + 1);
    kept = r >> d;
    g    = ((r >> (d - 1)) & 1) != 0;
    st   = ((r & ((64'd1 << (d - 1)) - 1)) != 0) || (r * r != n);
    if (g && (st || kept[0])) kept++;
    rexp = (e2 - s) / 2 + d + mw + bias;
    if (kept == (64'd1 << (mw + 1))) begin
      kept = kept >> 1;
      rexp++;
    end
    res     = 32'((longint'(rexp) << mw) | (kept & ((64'd1 << mw) - 1)));
    inexact = g | st;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] dout, held, exp_res;
    logic [3:0]  fl, held_fl;
    logic        exp_inex, seen;
    logic [31:0] rnd_in;
    int          lat;

    vecs.push_back('{0, 32'h4400, 32'h4000, 4'b0000, 15});
    vecs.push_back('{0, 32'h4000, 32'h3DA8, 4'b0001, 15});
    vecs.push_back('{0, 32'h0001, 32'h0C00, 4'b0000, 15});
    vecs.push_back('{0, 32'h0200, 32'h1DA8, 4'b0001, 15});
    vecs.push_back('{0, 32'h3C00, 32'h3C00, 4'b0000, 15});
    vecs.push_back('{0, 32'hBC00, 32'hFE00, 4'b1010, 2});
    vecs.push_back('{0, 32'hFC00, 32'hFE00, 4'b1010, 2});
    vecs.push_back('{0, 32'h8000, 32'h8000, 4'b0000, 2});
    vecs.push_back('{0, 32'h0000, 32'h0000, 4'b0000, 2});
    vecs.push_back('{0, 32'h7C00, 32'h7C00, 4'b0100, 2});
    vecs.push_back('{0, 32'h7D00, 32'h7F00, 4'b1010, 2});
    vecs.push_back('{0, 32'h7E01, 32'h7E01, 4'b1000, 2});
    vecs.push_back('{0, 32'hFD00, 32'hFF00, 4'b1010, 2});
    vecs.push_back('{1, 32'h40800000, 32'h40000000, 4'b0000, 28});
    vecs.push_back('{1, 32'h40000000, 32'h3FB504F3, 4'b0001, 28});

    #3;
    checkOutput("reset in_ready", 64'(ir0), 64'(0));
    checkOutput("reset out_valid", 64'(ov0), 64'(0));
    checkOutput("reset out_data", 64'(od0), 64'(0));
    checkOutput("reset flags", 64'({nan0, pinf0, inv0, inex0}), 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("ready after reset", 64'(ir0), 64'(1));

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].which, vecs[i].din, dout, fl, lat);
      checkOutput($sformatf("vec%0d data", i), 64'(dout), 64'(vecs[i].dout));
      checkOutput($sformatf("vec%0d flags", i), 64'(fl), 64'(vecs[i].fl));
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    $display("[TB] output hold under back-pressure");
    startOp(0, 32'h4400);
    waitResult(0, lat);
    held    = {16'h0, od0};
    held_fl = {nan0, pinf0, inv0, inex0};
    checkOutput("hold first data", 64'(held), 64'(32'h4000));
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      iv0 = 1'b1;
      id0 = 16'h3C00;
      checkOutput($sformatf("hold%0d in_ready", k), 64'(ir0), 64'(0));
      @(posedge CLK);
      #1;
      iv0 = 1'b0;
      checkOutput($sformatf("hold%0d valid", k), 64'(ov0), 64'(1));
      checkOutput($sformatf("hold%0d data", k), 64'(od0), 64'(held));
      checkOutput($sformatf("hold%0d flags", k), 64'({nan0, pinf0, inv0, inex0}), 64'(held_fl));
    end
    releaseOut(0);
    checkOutput("release valid low", 64'(ov0), 64'(0));
    checkOutput("release ready", 64'(ir0), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (ov0) seen = 1'b1;
    end
    checkOutput("no queued operand", 64'(seen), 64'(0));

    $display("[TB] reset during iteration");
    startOp(0, 32'h4400);
    repeat (5) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrst valid", 64'(ov0), 64'(0));
    checkOutput("midrst ready", 64'(ir0), 64'(0));
    checkOutput("midrst data", 64'(od0), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("midrst ready after", 64'(ir0), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (ov0) seen = 1'b1;
    end
    checkOutput("midrst no output", 64'(seen), 64'(0));
    applyStimulus(0, 32'h4400, dout, fl, lat);
    checkOutput("postrst data", 64'(dout), 64'(32'h4000));
    checkOutput("postrst latency", 64'(lat), 64'(15));

    $display("[TB] random positive operands");
    for (int i = 0; i < 40; i++) begin
      rnd_in = {17'h0, 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
      if (rnd_in[14:0] == 15'h0) rnd_in = 32'h0001;
      refSqrt(rnd_in, 5, 10, exp_res, exp_inex);
      applyStimulus(0, rnd_in, dout, fl, lat);
      checkOutput($sformatf("rnd%0d %h data", i, rnd_in[15:0]), 64'(dout), 64'(exp_res));
      checkOutput($sformatf("rnd%0d %h flags", i, rnd_in[15:0]), 64'(fl), 64'({3'b000, exp_inex}));
      checkOutput($sformatf("rnd%0d latency", i), 64'(lat), 64'(15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
